// File: rtl/lcd_hd44780_rx_if.sv
// HD44780-style parallel LCD bus: controller-driven strobe/select/data,
// responder-driven read data and busy flag.
interface lcd_hd44780_rx_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic [7:0] RD_DATA;
    logic       BUSY;

    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_DATA,
        input  RD_DATA, BUSY
    );

    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_DATA,
        output RD_DATA, BUSY
    );
endinterface

// File: rtl/lcd_hd44780_rx.sv
// lcd_hd44780_rx: receiving end of the HD44780-style character-LCD bus.
// Oversamples E/RS/RW/DATA, decodes each E falling edge into instruction or
// DDRAM effects, keeps an 80-byte DDRAM shadow with address counter and
// mode flags, and answers reads with busy flag / DDRAM data.
module lcd_hd44780_rx #(
    parameter int unsigned BUSY_CYCLES  = 4,
    parameter int unsigned CLEAR_CYCLES = 80
) (
    input  logic               CLK,
    input  logic               RESETN,
    lcd_hd44780_rx_if.slave    bus,
    output logic [6:0]         AC,
    output logic               DISP_ON,
    output logic               CURSOR_ON,
    output logic               BLINK_ON,
    output logic               ID,
    output logic               SH,
    output logic               DL,
    output logic               N,
    output logic               F,
    output logic               CMD_STROBE,
    input  logic [6:0]         VIEW_ADDR,
    output logic [7:0]         VIEW_CHAR,
    output logic               ERR_BUSY,
    output logic               ERR_ADDR,
    input  logic               ERR_CLR
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    localparam logic [6:0] LAST_IDX = 7'(CLEAR_CYCLES - 1);

    // Valid DDRAM addresses: 0x00-0x27 (line 1), 0x40-0x67 (line 2).
    function automatic logic f_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Physical DDRAM index; line 2 is packed directly after line 1.
    function automatic logic [6:0] f_idx(input logic [6:0] a);
        return (a < 7'h40) ? a : (a - 7'h18);
    endfunction

    // Address-counter step with the line-to-line wrap points.
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (a == 7'h27)      nxt = 7'h40;
            else if (a == 7'h67) nxt = 7'h00;
            else                 nxt = a + 7'd1;
        end else begin
            if (a == 7'h00)      nxt = 7'h67;
            else if (a == 7'h40) nxt = 7'h27;
            else                 nxt = a - 7'd1;
        end
        return nxt;
    endfunction

    logic       r_e_s1, r_e_s2, r_e_s3;
    logic       r_rs_s1, r_rs_s2, r_rs_s3;
    logic       r_rw_s1, r_rw_s2, r_rw_s3;
    logic [7:0] r_d_s1, r_d_s2, r_d_s3;

    state_t     r_state;
    logic       r_busy;
    logic [7:0] r_cnt;
    logic [6:0] r_clr_idx;
    logic       r_strobe;

    logic [6:0] r_ac;
    logic       r_disp, r_cur, r_blink, r_id, r_sh, r_dl, r_n, r_f;
    logic       r_err_busy, r_err_addr;
    logic [7:0] r_rd;
    logic [7:0] r_view;
    logic [7:0] r_ddram [CLEAR_CYCLES];

    logic       w_xfer, w_bfread, w_take, w_drop, w_is_ir_wr;
    logic       w_bad, w_clear, w_exec;
    logic       w_we;
    logic [6:0] w_waddr;
    logic [7:0] w_wdata;

    // Three-stage synchroniser for all bus inputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            {r_e_s1, r_e_s2, r_e_s3}    <= '0;
            {r_rs_s1, r_rs_s2, r_rs_s3} <= '0;
            {r_rw_s1, r_rw_s2, r_rw_s3} <= '0;
            r_d_s1 <= '0;
            r_d_s2 <= '0;
            r_d_s3 <= '0;
        end else begin
            {r_e_s1, r_e_s2, r_e_s3}    <= {bus.LCD_E, r_e_s1, r_e_s2};
            {r_rs_s1, r_rs_s2, r_rs_s3} <= {bus.LCD_RS, r_rs_s1, r_rs_s2};
            {r_rw_s1, r_rw_s2, r_rw_s3} <= {bus.LCD_RW, r_rw_s1, r_rw_s2};
            r_d_s1 <= bus.LCD_DATA;
            r_d_s2 <= r_d_s1;
            r_d_s3 <= r_d_s2;
        end
    end

    // Transfer classification on the synchronised E falling edge.
    assign w_xfer     = r_e_s3 & ~r_e_s2;
    assign w_bfread   = w_xfer & ~r_rs_s3 & r_rw_s3;
    assign w_take     = w_xfer & ~w_bfread & ~r_busy;
    assign w_drop     = w_xfer & ~w_bfread & r_busy;
    assign w_is_ir_wr = ~r_rs_s3 & ~r_rw_s3;
    assign w_bad      = w_take & w_is_ir_wr & r_d_s3[7] & ~f_valid(r_d_s3[6:0]);
    assign w_clear    = w_take & w_is_ir_wr & (r_d_s3 == 8'h01);
    assign w_exec     = w_take & ~w_bad & ~w_clear;

    // Busy sequencer: execution delay or clear-display fill.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state   <= S_CLEAR;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_clr_idx <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= w_bfread | w_exec | w_clear;
            case (r_state)
                S_IDLE: begin
                    if (w_clear) begin
                        r_state   <= S_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_idx <= '0;
                    end else if (w_exec) begin
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'(BUSY_CYCLES);
                    end
                end
                S_EXEC: begin
                    if (r_cnt <= 8'd1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 7'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Address counter, mode flags and sticky error flags.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_ac       <= '0;
            r_id       <= 1'b1;
            r_sh       <= 1'b0;
            r_disp     <= 1'b0;
            r_cur      <= 1'b0;
            r_blink    <= 1'b0;
            r_dl       <= 1'b1;
            r_n        <= 1'b0;
            r_f        <= 1'b0;
            r_err_busy <= 1'b0;
            r_err_addr <= 1'b0;
        end else begin
            if (w_drop)       r_err_busy <= 1'b1;
            else if (ERR_CLR) r_err_busy <= 1'b0;
            if (w_bad)        r_err_addr <= 1'b1;
            else if (ERR_CLR) r_err_addr <= 1'b0;

            if (w_clear) begin
                r_ac <= '0;
                r_id <= 1'b1;
            end else if (w_exec) begin
                if (r_rs_s3) begin
                    r_ac <= f_step(r_ac, r_id);
                end else begin
                    casez (r_d_s3)
                        8'b1???????: r_ac <= r_d_s3[6:0];
                        8'b01??????: ;
                        8'b001?????: {r_dl, r_n, r_f} <= r_d_s3[4:2];
                        8'b0001????: r_ac <= f_step(r_ac, r_d_s3[2]);
                        8'b00001???: {r_disp, r_cur, r_blink} <= r_d_s3[2:0];
                        8'b000001??: {r_id, r_sh} <= r_d_s3[1:0];
                        8'b0000001?: r_ac <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // DDRAM write port: clear fill has priority, otherwise accepted data write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = f_idx(r_ac);
        w_wdata = r_d_s3;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = 8'h20;
        end else if (w_exec && r_rs_s3 && !r_rw_s3) begin
            w_we = 1'b1;
        end
        if (!RESETN) w_we = 1'b0;
    end

    // DDRAM storage.
    always_ff @(posedge CLK) begin
        if (w_we) r_ddram[w_waddr] <= w_wdata;
    end

    // Registered bus read data and mirror readout.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_rd   <= '0;
            r_view <= '0;
        end else begin
            r_rd   <= r_rs_s2 ? r_ddram[f_idx(r_ac)] : {r_busy, r_ac};
            r_view <= f_valid(VIEW_ADDR) ? r_ddram[f_idx(VIEW_ADDR)] : 8'h20;
        end
    end

    assign bus.RD_DATA = r_rd;
    assign bus.BUSY    = r_busy;
    assign AC          = r_ac;
    assign DISP_ON     = r_disp;
    assign CURSOR_ON   = r_cur;
    assign BLINK_ON    = r_blink;
    assign ID          = r_id;
    assign SH          = r_sh;
    assign DL          = r_dl;
    assign N           = r_n;
    assign F           = r_f;
    assign CMD_STROBE  = r_strobe;
    assign VIEW_CHAR   = r_view;
    assign ERR_BUSY    = r_err_busy;
    assign ERR_ADDR    = r_err_addr;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Testbench for lcd_hd44780_rx: directed scenarios plus randomized bus
// transfers checked against a behavioural display model via a scoreboard.
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;

    localparam int unsigned BC = 8;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [6:0] AC;
    logic       DISP_ON, CURSOR_ON, BLINK_ON, ID, SH, DL, N, F, CMD_STROBE;
    logic [6:0] VIEW_ADDR;
    logic [7:0] VIEW_CHAR;
    logic       ERR_BUSY, ERR_ADDR, ERR_CLR;

    always #5 CLK = ~CLK;

    lcd_hd44780_rx_if bus ();

    lcd_hd44780_rx #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(80)) dut (
        .CLK(CLK), .RESETN(RESETN), .bus(bus),
        .AC(AC), .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON), .BLINK_ON(BLINK_ON),
        .ID(ID), .SH(SH), .DL(DL), .N(N), .F(F), .CMD_STROBE(CMD_STROBE),
        .VIEW_ADDR(VIEW_ADDR), .VIEW_CHAR(VIEW_CHAR),
        .ERR_BUSY(ERR_BUSY), .ERR_ADDR(ERR_ADDR), .ERR_CLR(ERR_CLR)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_strobes = 0;

    typedef struct packed {
        logic [14:0] st;
        logic        busy;
        logic        chk_busy;
    } exp_t;
    exp_t q[$];

    // Behavioural display model, indexed directly by bus address.
    logic [7:0] m_dd [128];
    logic [6:0] m_ac;
    logic m_id, m_sh, m_disp, m_cur, m_blink, m_dl, m_n, m_f;
    logic [6:0] vlist [80];
    logic [6:0] bnd [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic m_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Cursor movement walks the ordered list of visible cells circularly.
    function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
        int p = 0;
        for (int i = 0; i < 80; i++) if (vlist[i] == a) p = i;
        return vlist[(p + (inc ? 1 : 79)) % 80];
    endfunction

    function automatic logic [14:0] m_state();
        return {m_ac, m_disp, m_cur, m_blink, m_id, m_sh, m_dl, m_n, m_f};
    endfunction

    task automatic m_clear();
        for (int a = 0; a < 128; a++) m_dd[a] = 8'h20;
        m_ac = '0;
        m_id = 1'b1;
    endtask

    task automatic m_reset();
        m_clear();
        {m_sh, m_disp, m_cur, m_blink, m_n, m_f} = '0;
        m_dl = 1'b1;
    endtask

    // Apply one non-busy transfer to the model and queue the expected strobe.
    task automatic m_apply(input logic rs, input logic rw, input logic [7:0] d);
        if (!rs && rw) begin
            q.push_back({m_state(), 1'b0, 1'b0});
            return;
        end
        if (rs) begin
            if (!rw) m_dd[m_ac] = d;
            m_ac = m_step(m_ac, m_id);
        end else if (d[7]) begin
            if (!m_valid(d[6:0])) return;
            m_ac = d[6:0];
        end else if (d[6]) begin
        end else if (d[5]) begin
            {m_dl, m_n, m_f} = d[4:2];
        end else if (d[4]) begin
            m_ac = m_step(m_ac, d[2]);
        end else if (d[3]) begin
            {m_disp, m_cur, m_blink} = d[2:0];
        end else if (d[2]) begin
            {m_id, m_sh} = d[1:0];
        end else if (d[1]) begin
            m_ac = '0;
        end else if (d[0]) begin
            m_clear();
        end
        q.push_back({m_state(), 1'b1, 1'b1});
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RESETN && CMD_STROBE === 1'b1) begin
            n_strobes++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_unexpected: got strobe with AC=0x%0h expected none", AC);
            end else begin
                e = q.pop_front();
                check("strobe_state",
                      {17'd0, AC, DISP_ON, CURSOR_ON, BLINK_ON, ID, SH, DL, N, F},
                      {17'd0, e.st});
                if (e.chk_busy) check("strobe_busy", {31'd0, bus.BUSY}, {31'd0, e.busy});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a transfer with E high for 3 cycles; for reads verify RD_DATA, then drop E.
    task automatic xfer_start(input logic rs, input logic rw, input logic [7:0] d);
        bus.LCD_RS = rs;
        bus.LCD_RW = rw;
        bus.LCD_DATA = d;
        bus.LCD_E = 1'b1;
        tick(); tick(); tick();
        if (rw) check("rd_data", {24'd0, bus.RD_DATA},
                      {24'd0, rs ? m_dd[m_ac] : {1'b0, m_ac}});
        m_apply(rs, rw, d);
        bus.LCD_E = 1'b0;
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        xfer_start(rs, rw, d);
        repeat (3) tick();
        if (!rs && !rw && d == 8'h01) repeat (88) tick();
        else repeat (BC + 4) tick();
    endtask

    task automatic view_one(input logic [6:0] a, input logic [7:0] exp);
        VIEW_ADDR = a;
        tick();
        check("view_one", {24'd0, VIEW_CHAR}, {24'd0, exp});
    endtask

    task automatic view_scan();
        for (int a = 0; a < 128; a++) begin
            VIEW_ADDR = 7'(a);
            tick();
            check("view_scan", {24'd0, VIEW_CHAR},
                  {24'd0, m_valid(7'(a)) ? m_dd[a] : 8'h20});
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int s0;
        int r;
        logic rs, rw;
        logic [7:0] d;
        logic [6:0] a;

        for (int i = 0; i < 40; i++) begin
            vlist[i] = 7'(i);
            vlist[i + 40] = 7'(8'h40 + i);
        end
        bnd[0] = 7'h00; bnd[1] = 7'h27; bnd[2] = 7'h40; bnd[3] = 7'h67;

        bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = '0;
        ERR_CLR = 1'b0;
        VIEW_ADDR = '0;
        RESETN = 1'b0;
        m_reset();
        repeat (3) tick();

        // Reset values
        check("rst_ac", {25'd0, AC}, 32'h0);
        check("rst_flags", {24'd0, DISP_ON, CURSOR_ON, BLINK_ON, ID, SH, DL, N, F}, 32'h14);
        check("rst_strobe_err", {29'd0, CMD_STROBE, ERR_BUSY, ERR_ADDR}, 32'h0);
        check("rst_rd_view", {16'd0, bus.RD_DATA, VIEW_CHAR}, 32'h0);

        // Post-reset fill: BUSY for exactly 80 cycles
        RESETN = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.BUSY === 1'b1 && cyc < 200);
        check("reset_fill_cycles", cyc, 80);
        view_scan();
        check("after_fill_ac_dl", {24'd0, AC, DL}, {24'd0, 7'h00, 1'b1});

        // Initialisation sequence
        s0 = n_strobes;
        xfer(0, 0, 8'h3C);
        xfer(0, 0, 8'h0C);
        xfer(0, 0, 8'h06);
        check("init_strobes", n_strobes - s0, 3);
        check("init_fn", {29'd0, DL, N, F}, 32'h7);
        check("init_disp", {29'd0, DISP_ON, CURSOR_ON, BLINK_ON}, 32'h4);
        check("init_entry", {30'd0, ID, SH}, 32'h2);
        check("init_err_busy", {31'd0, ERR_BUSY}, 32'h0);

        // Line wrap on increment
        xfer(0, 0, 8'hA7);
        xfer(1, 0, 8'h41);
        check("wrap_27_40", {25'd0, AC}, 32'h40);
        view_one(7'h27, 8'h41);
        xfer(0, 0, 8'hE7);
        xfer(1, 0, 8'h42);
        check("wrap_67_00", {25'd0, AC}, 32'h00);
        view_one(7'h67, 8'h42);

        // Line wrap on decrement
        xfer(0, 0, 8'h04);
        xfer(0, 0, 8'hC0);
        xfer(1, 0, 8'h43);
        view_one(7'h40, 8'h43);
        check("wrap_40_27", {25'd0, AC}, 32'h27);

        // Out-of-range DDRAM address
        xfer(0, 0, 8'hAA);
        check("bad_addr_err", {31'd0, ERR_ADDR}, 32'h1);
        check("bad_addr_ac", {25'd0, AC}, 32'h27);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("err_addr_clr", {31'd0, ERR_ADDR}, 32'h0);

        // Write while busy is dropped; busy-flag read still answers
        xfer(0, 0, 8'h06);
        xfer_start(1, 0, 8'h31);
        tick(); tick();
        bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h55; bus.LCD_E = 1'b1;
        tick();
        check("busy_after_write", {31'd0, bus.BUSY}, 32'h1);
        tick();
        bus.LCD_E = 1'b0;
        tick();
        bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b1; bus.LCD_E = 1'b1;
        m_apply(0, 1, 8'h00);
        tick(); tick();
        check("err_busy_dropped", {31'd0, ERR_BUSY}, 32'h1);
        bus.LCD_E = 1'b0;
        tick();
        check("rd_busy_flag", {24'd0, bus.RD_DATA}, {24'd0, 1'b1, m_ac});
        tick(); tick();
        check("busy_last_cycle", {31'd0, bus.BUSY}, 32'h1);
        tick();
        check("busy_released", {31'd0, bus.BUSY}, 32'h0);
        repeat (4) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("err_busy_clr", {31'd0, ERR_BUSY}, 32'h0);
        view_scan();

        // Randomized transfers against the model
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 99);
            rs = 1'b0; rw = 1'b0; d = 8'($urandom_range(0, 255));
            if (r < 30) begin
                rs = 1'b1; d = 8'($urandom_range(32, 126));
            end else if (r < 42) begin
                rs = 1'b1; rw = 1'b1;
            end else if (r < 52) begin
                a = ($urandom_range(0, 1) == 1) ? bnd[$urandom_range(0, 3)] : vlist[$urandom_range(0, 79)];
                d = {1'b1, a};
            end else if (r < 58) d = 8'h04 | 8'($urandom_range(0, 3));
            else if (r < 64) d = 8'h08 | 8'($urandom_range(0, 7));
            else if (r < 69) d = 8'h20 | 8'($urandom_range(0, 31));
            else if (r < 79) d = 8'h10 | 8'($urandom_range(0, 15));
            else if (r < 83) d = 8'h02 | 8'($urandom_range(0, 1));
            else if (r < 86) d = 8'h40 | 8'($urandom_range(0, 63));
            else if (r < 88) d = 8'h00;
            else if (r < 90) d = 8'h01;
            else rw = 1'b1;
            xfer(rs, rw, d);
        end
        check("rand_errs", {30'd0, ERR_BUSY, ERR_ADDR}, 32'h0);
        view_scan();

        // Reset mid-fill restarts the fill; transfer during fill dropped, error beats ERR_CLR
        RESETN = 1'b0;
        tick(); tick();
        RESETN = 1'b1;
        repeat (30) tick();
        RESETN = 1'b0;
        tick(); tick();
        RESETN = 1'b1;
        m_reset();
        cyc = 0;
        do begin
            if (cyc == 5) begin
                bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h77; bus.LCD_E = 1'b1;
            end
            if (cyc == 9) bus.LCD_E = 1'b0;
            if (cyc == 11) ERR_CLR = 1'b1;
            if (cyc == 12) begin
                ERR_CLR = 1'b0;
                check("err_busy_wins", {31'd0, ERR_BUSY}, 32'h1);
            end
            tick();
            cyc++;
        end while (bus.BUSY === 1'b1 && cyc < 200);
        check("refill_cycles", cyc, 80);
        check("refill_ac", {25'd0, AC}, 32'h0);
        view_scan();
        check("err_busy_sticky", {31'd0, ERR_BUSY}, 32'h1);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
- Receiving end of the HD44780-style parallel character-LCD bus that our LCD controller drives.
- Decodes every E-strobed transfer into instruction-register and DDRAM effects, and keeps an 80-byte DDRAM shadow, the address counter and the mode flags.
- Drives busy flag and read data back to the bus.
- Used as an on-chip display mirror (VIEW port) and as the bus responder for controller verification. It runs on its own oversampling clock, at least 4x the controller's E rate.

Parameters:
BUSY_CYCLES, 4, CLK cycles BUSY stays high after any accepted non-clear transfer (1..255)
CLEAR_CYCLES, 80, CLK cycles of the clear-display fill, one DDRAM cell per cycle (fixed at 80, must equal DDRAM size)

Ports:
CLK  in  1  clock
RESETN  in  1  synchronous, active-low reset
LCD_E  in  1  bus enable; a transfer completes on its falling edge
LCD_RS  in  1  0 = instruction register, 1 = data register
LCD_RW  in  1  0 = write, 1 = read
LCD_DATA  in  8  bus write data
RD_DATA  out  8  bus read data: {BUSY,AC} when RS=0, else DDRAM[AC]
BUSY  out  1  busy flag
AC  out  7  DDRAM address counter
DISP_ON, CURSOR_ON, BLINK_ON  out  1 each  display-control bits D, C, B
ID, SH  out  1 each  entry-mode bits
DL, N, F  out  1 each  function-set bits
CMD_STROBE  out  1  1-cycle pulse per accepted transfer
VIEW_ADDR  in  7  DDRAM address for mirror readout
VIEW_CHAR  out  8  DDRAM[VIEW_ADDR], registered, 1 cycle latency
ERR_BUSY  out  1  sticky: write or data-read arrived while BUSY=1
ERR_ADDR  out  1  sticky: set-DDRAM-address was out of range
ERR_CLR  in  1  clears ERR_BUSY and ERR_ADDR

Behaviour:
- Input sampling
  - LCD_E, LCD_RS, LCD_RW and LCD_DATA pass through a 3-stage register pipe (s1, s2, s3).
  - A transfer is detected when e_s2=0 and e_s3=1. It uses rs_s3, rw_s3 and d_s3.
  - Bus signals must be stable for at least 2 CLK before E falls.
- Latency
  - All effects of a transfer (DDRAM write, AC, flags, CMD_STROBE, BUSY rising) are visible after the 3rd CLK edge that samples LCD_E=0.
- Address map
  - Valid DDRAM addresses are 0x00-0x27 (line 1) and 0x40-0x67 (line 2).
  - Physical index is addr for line 1 and addr-0x18 for line 2.
  - VIEW_ADDR outside the valid ranges returns 0x20.
- AC step on data write or data read
  - ID=1 increments: 0x27->0x40 and 0x67->0x00.
  - ID=0 decrements: 0x00->0x67 and 0x40->0x27.
- Instruction decode (RS=0, RW=0); the first matching set bit wins, checked MSB first:
  - 1xxxxxxx: AC=d[6:0] if valid; otherwise ignored and ERR_ADDR set.
  - 01xxxxxx (CGRAM address): accepted, no state change.
  - 001xxxxx: DL=d4, N=d3, F=d2.
  - 0001xxxx: AC steps by one (d2=1 right/increment, d2=0 left/decrement) with the wrap rules above; display shift is not modelled.
  - 00001xxx: DISP_ON=d2, CURSOR_ON=d1, BLINK_ON=d0.
  - 000001xx: ID=d1, SH=d0.
  - 0000001x: AC=0.
  - 00000001: clear display.
  - 0x00: accepted, no-op.
- Data write (RS=1, RW=0): DDRAM[AC]=d, then AC steps.
- Data read (RS=1, RW=1): AC steps after the transfer. Data read counts as a busy operation.
- Busy-flag read (RS=0, RW=1): always accepted, even while busy. No state change, no BUSY. CMD_STROBE still pulses.
- RD_DATA is registered every cycle from rs_s2: {BUSY,AC} or DDRAM[AC].
- FSM
  - IDLE: on an accepted busy-type transfer go to EXEC (counter=BUSY_CYCLES), or CLEAR if the transfer was clear display.
  - EXEC: BUSY=1, counter counts down, return to IDLE at 0.
  - CLEAR: BUSY=1, writes 0x20 to index 0..79 one cycle each, sets AC=0 and ID=1 on entry, returns to IDLE after index 79.
- While BUSY=1, any transfer except a busy-flag read is dropped: no state change, ERR_BUSY set, no CMD_STROBE.
- Simultaneous ERR_CLR and a new error: the error wins, flag stays 1.
- Reset
  - Values: AC=0, ID=1, SH=0, DISP_ON=0, CURSOR_ON=0, BLINK_ON=0, DL=1, N=0, F=0, CMD_STROBE=0, ERR_*=0, RD_DATA=0x00, VIEW_CHAR=0x00, sync pipe cleared to 0.
  - On release, the FSM enters CLEAR, so BUSY=1 for 80 cycles and DDRAM is filled with 0x20.
  - Reset asserted mid-clear or mid-EXEC aborts the operation and the fill restarts from index 0 on release.
- Transfers detected during the post-reset fill are dropped with ERR_BUSY set.

Test Plan:
1. Reset, wait 80 CLK -> BUSY falls at cycle 80; VIEW_CHAR=0x20 for all 80 valid addresses; AC=0x00; DL=1.
2. Write 0x3C, 0x0C, 0x06, each spaced ≥BUSY_CYCLES+4 CLK -> DL=1,N=1,F=1; DISP_ON=1,CURSOR_ON=0,BLINK_ON=0; ID=1,SH=0; 3 CMD_STROBE pulses; ERR_BUSY=0.
3. Cmd 0xA7 (AC=0x27), then data 0x41 -> DDRAM[0x27]=0x41 and AC=0x40; cmd 0xE7, then data 0x42 -> AC wraps to 0x00.
4. Cmd 0x04 (ID=0), cmd 0xC0, then data 0x43 -> DDRAM[0x40]=0x43 and AC=0x27.
5. Cmd 0xAA -> AC unchanged, ERR_ADDR=1; pulse ERR_CLR -> ERR_ADDR=0.
6. Data write 0x31, then a second write 2 CLK after detection -> second write dropped, ERR_BUSY=1; a busy-flag read in the same window gives RD_DATA[7]=1.
